// File: rtl/polyphase_s2p.sv
// Serial-to-parallel polyphase splitter: groups PHASE_NUM valid samples, aligned to start_i, into one frame.
// Optional macro POLYPHASE_HOLD_EN keeps phases_o at the last frame between strobes instead of zeroing it.
module polyphase_s2p #(
  parameter int DATA_W    = 11,
  parameter int PHASE_NUM = 4,
  parameter int CNT_W     = $clog2(PHASE_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          valid_i,
  input  logic [DATA_W-1:0]             x_i,
  output logic                          frame_valid_o,
  output logic [PHASE_NUM*DATA_W-1:0]   phases_o,
  output logic                          sync_err_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PHASE_NUM - 1);

  state_t                              state_r;
  state_t                              state_nxt_s;
  logic [CNT_W-1:0]                    cnt_r;
  logic [CNT_W-1:0]                    cnt_nxt_s;
  logic [CNT_W-1:0]                    idx_s;
  logic [PHASE_NUM-2:0][DATA_W-1:0]    sh_r;
  logic                                accept_s;
  logic                                last_s;
  logic                                err_s;
  logic [PHASE_NUM*DATA_W-1:0]         frame_s;
  logic [PHASE_NUM*DATA_W-1:0]         phases_nxt_s;
  logic                                frame_valid_r;
  logic                                sync_err_r;
  logic [PHASE_NUM*DATA_W-1:0]         phases_r;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start_i is the only way out of IDLE, and RUN is left only by reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sample acceptance, index, counter update and sync-error detection
  always_comb begin
    accept_s  = valid_i && (start_i || (state_r == RUN));
    idx_s     = start_i ? {CNT_W{1'b0}} : cnt_r;
    last_s    = accept_s && (idx_s == LAST_IDX);
    err_s     = start_i && (state_r == RUN) && (cnt_r != {CNT_W{1'b0}});
    cnt_nxt_s = cnt_r;
    if (accept_s) begin
      if (last_s) begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = idx_s + CNT_W'(1);
      end
    end else if (start_i) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Output logic: phase 0 is the newest sample, the highest phase the oldest
  always_comb begin
    frame_s = '0;
    frame_s[0 +: DATA_W] = x_i;
    for (int k = 1; k < PHASE_NUM; k++) begin
      frame_s[k*DATA_W +: DATA_W] = sh_r[k-1];
    end
    if (last_s) begin
      phases_nxt_s = frame_s;
    end else begin
`ifdef POLYPHASE_HOLD_EN
      phases_nxt_s = phases_r;
`else
      phases_nxt_s = '0;
`endif
    end
  end

  // Counter and shift line
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r <= {CNT_W{1'b0}};
      sh_r  <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (accept_s) begin
        sh_r[0] <= x_i;
        for (int k = 1; k < PHASE_NUM - 1; k++) begin
          sh_r[k] <= sh_r[k-1];
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      phases_r      <= '0;
    end else begin
      frame_valid_r <= last_s;
      sync_err_r    <= err_s;
      phases_r      <= phases_nxt_s;
    end
  end

  assign frame_valid_o = frame_valid_r;
  assign sync_err_o    = sync_err_r;
  assign phases_o      = phases_r;

endmodule

// File: doc/polyphase_s2p.md
# polyphase_s2p

Parametrised serial-to-parallel polyphase splitter for the direct polyphase decomposition path. It collects `PHASE_NUM` consecutive valid input samples into one frame and presents all phases in parallel with a single-cycle frame strobe. Frames are aligned to `start_i`, and input samples are qualified by `valid_i`. It sits between the sample source and the per-phase sub-filters, and generalises the fixed 4-phase, 11-bit splitter.

## Interface
- `DATA_W`, default 11: sample width in bits.
- `PHASE_NUM`, default 4: phases per frame; legal values are 2 or more.
- `CNT_W`, default `$clog2(PHASE_NUM)`: width of the internal sample counter (derived).

Ports:
- `clk_i`  in  1: the single clock; all logic is on its rising edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `start_i`  in  1: frame alignment; the sample accepted in the same cycle is sample 0 of a new frame.
- `valid_i`  in  1: `x_i` is valid this cycle.
- `x_i`  in  `DATA_W`: input sample.
- `frame_valid_o`  out  1: one-cycle strobe; `phases_o` holds a complete frame.
- `phases_o`  out  `PHASE_NUM*DATA_W`: phase k is at `[k*DATA_W +: DATA_W]`.
- `sync_err_o`  out  1: one-cycle pulse; a partial frame was discarded by `start_i`.

## Operation
- The FSM has two states, IDLE and RUN. Reset enters IDLE.
- **IDLE:** `valid_i` samples are ignored. `start_i` moves the FSM to RUN.
  - If `start_i` and `valid_i` are high together, that sample is accepted as sample 0 and cnt becomes 1.
  - If `start_i` is high without `valid_i`, cnt is 0.
- **RUN:** a sample is accepted in every cycle with `valid_i` high. Each accepted sample shifts into the shift line: `sh[0] <= x_i`, `sh[k+1] <= sh[k]`. Cycles without `valid_i` leave both the shift line and cnt unchanged.
- **Sample index:** idx = 0 if `start_i`, otherwise cnt.
  - On an accepted sample with idx < `PHASE_NUM`-1: cnt <= idx+1.
  - On an accepted sample with idx == `PHASE_NUM`-1 (frame complete): cnt <= 0. The output register loads phase 0 = `x_i` (newest) and phase k = `sh[k-1]`, so phase `PHASE_NUM`-1 is the oldest sample. `frame_valid_o` <= 1 for one cycle.
- **`start_i` in RUN with cnt != 0:** the partial frame is dropped and `sync_err_o` pulses for one cycle. Restart then proceeds as above. `start_i` with cnt == 0 raises no error.
- **Back-to-back frames:** continuous `valid_i` produces a `frame_valid_o` strobe every `PHASE_NUM` cycles with no bubble.
- **Arithmetic:** none; samples pass through bit-exact. The counter wraps only via the frame-complete rule and never exceeds `PHASE_NUM`-1.

## Timing
- Reset values: `frame_valid_o`=0, `phases_o`=0, `sync_err_o`=0, cnt=0, shift line=0, state IDLE.
- **Latency:** the last sample of a frame is sampled at edge N. `frame_valid_o` and `phases_o` are valid from edge N until edge N+1.
- **Error flag:** `sync_err_o` is registered and asserted from the edge that samples the offending `start_i`.
- **Reset mid-frame:** all outputs go to 0 immediately (asynchronously). A partial frame is lost, and no strobe or error is generated afterwards. `start_i` is required again.
- No backpressure: downstream logic must consume each frame in its strobe cycle (or rely on hold mode).

## Configuration
- Macro: `POLYPHASE_HOLD_EN`.
- **Undefined (default):** `phases_o` is forced to 0 whenever `frame_valid_o` is 0.
- **Defined:** `phases_o` holds the last completed frame until the next frame or reset. `frame_valid_o` and `sync_err_o` are unchanged.

## Test plan
All scenarios use `DATA_W`=11 and `PHASE_NUM`=4.
1. Reset, then `valid_i` with x=7,8,9,10 and no `start_i` -> no `frame_valid_o`; all outputs stay 0.
2. `start_i`+`valid_i` on x=1, then x=2,3,4 on consecutive cycles -> `frame_valid_o`=1 for one cycle after the x=4 edge, with p0=4, p1=3, p2=2, p3=1. Continue with x=5..8 -> next strobe exactly 4 cycles later with p0=8..p3=5.
3. Gapped valid (1, gap, 2, gap, gap, 3, 4) after `start_i` on 1 -> exactly one strobe after 4, with p0=4, p1=3, p2=2, p3=1.
4. Frame 1,2 then `start_i`+valid on 20, then 21,22,23 -> `sync_err_o` pulses once after the 20 edge; the frame is p0=23, p1=22, p2=21, p3=20; values 1 and 2 never appear.
5. Reset asserted after 3 samples -> all outputs 0 immediately. After release, x=9..12 without `start_i` -> no strobe.
6. Scenario 2 repeated with and without `POLYPHASE_HOLD_EN` -> with the macro, `phases_o` stays {4,3,2,1} between strobes; without it, `phases_o` is 0 between strobes.
